// File: rtl/core_scheduler.sv
// Round-robin scheduler that hands point indices to validator cores, collects
// their inlier/outlier verdicts and packs outlier indices into output words.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting for start after reset
//   S_SEED  | giving each core its first index, one core per cycle
//   S_RUN   | arbitrating core results, reissuing indices, packing outliers
//   S_FLUSH | pushing out a partially filled pack word before finishing
//   S_DONE  | run complete; done held until the next start
module core_scheduler #(
  parameter int N           = 16,
  parameter int CORE_NUMBER = 2,
  parameter int PACK        = 2,
  localparam int CW         = $clog2(PACK + 1),
  localparam int RRW        = (CORE_NUMBER > 1) ? $clog2(CORE_NUMBER) : 1
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [N-1:0]             point_cloud_size,
  input  logic [CORE_NUMBER-1:0]   core_inlier,
  input  logic [CORE_NUMBER-1:0]   core_outlier,
  output logic [CORE_NUMBER-1:0]   core_reset,
  output logic [N*CORE_NUMBER-1:0] core_point_idx,
  output logic [N*PACK-1:0]        out_data,
  output logic [CW-1:0]            out_count,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic [2:0] {S_IDLE, S_SEED, S_RUN, S_FLUSH, S_DONE} state_e;

  state_e                 state_q, state_d;
  logic [N-1:0]           size_q, size_d;
  logic [N-1:0]           next_idx_q, next_idx_d;
  logic [RRW-1:0]         rr_q, rr_d;
  logic [RRW-1:0]         seed_q, seed_d;
  logic [CORE_NUMBER-1:0] rst_q, rst_d;
  logic [CORE_NUMBER-1:0] retired_q, retired_d;
  logic [CORE_NUMBER-1:0] armed_q, armed_d;
  logic [N-1:0]           idx_q [CORE_NUMBER];
  logic [N-1:0]           idx_d [CORE_NUMBER];
  logic [N-1:0]           buf_q [PACK];
  logic [N-1:0]           buf_d [PACK];
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [N*PACK-1:0]      odata_q, odata_d;
  logic [CW-1:0]          ocnt_q, ocnt_d;
  logic                   ovalid_q, ovalid_d;

  logic                   out_free;
  logic                   stall;
  logic                   transfer;
  logic [CORE_NUMBER-1:0] cand;
  logic                   gnt_valid;
  logic [RRW-1:0]         gnt_id;
  logic [RRW-1:0]         pos;
  logic [CW-1:0]          cnt_base;

  // The output register can take a new word if empty or being drained now.
  assign out_free = !ovalid_q || out_ready;
  // A full pack that cannot move blocks any further outlier from being taken.
  assign stall    = (cnt_q == CW'(PACK)) && !out_free;
  assign transfer = out_free && (cnt_q != '0) &&
                    ((cnt_q == CW'(PACK)) || (state_q == S_FLUSH));
  assign cand     = armed_q & (core_inlier | core_outlier) &
                    ~({CORE_NUMBER{stall}} & core_outlier);

  // Round-robin search for one core with an acceptable result, starting at rr.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = '0;
    pos       = '0;
    for (int k = 0; k < CORE_NUMBER; k++) begin
      pos = RRW'((int'(rr_q) + k) % CORE_NUMBER);
      if (!gnt_valid && cand[pos]) begin
        gnt_valid = 1'b1;
        gnt_id    = pos;
      end
    end
    if (state_q != S_RUN) gnt_valid = 1'b0;
  end

  // Next-state: FSM, core bookkeeping, packing and output register.
  always_comb begin
    state_d    = state_q;
    size_d     = size_q;
    next_idx_d = next_idx_q;
    rr_d       = rr_q;
    seed_d     = seed_q;
    idx_d      = idx_q;
    buf_d      = buf_q;
    cnt_d      = cnt_q;
    odata_d    = odata_q;
    ocnt_d     = ocnt_q;
    ovalid_d   = ovalid_q && !out_ready;
    retired_d  = retired_q;
    rst_d      = retired_q;
    armed_d    = ~rst_q & ~retired_q;
    cnt_base   = cnt_q;

    if (transfer) begin
      for (int j = 0; j < PACK; j++) begin
        odata_d[N*PACK-1-j*N -: N] = (CW'(j) < cnt_q) ? buf_q[j] : '1;
      end
      ocnt_d   = cnt_q;
      ovalid_d = 1'b1;
      cnt_base = '0;
      cnt_d    = '0;
    end

    if (gnt_valid) begin
      if (core_outlier[gnt_id]) begin
        for (int j = 0; j < PACK; j++) begin
          if (CW'(j) == cnt_base) buf_d[j] = idx_q[gnt_id];
        end
        cnt_d = cnt_base + CW'(1);
      end
      rst_d[gnt_id]   = 1'b1;
      armed_d[gnt_id] = 1'b0;
      if (next_idx_q < size_q) begin
        idx_d[gnt_id] = next_idx_q;
        next_idx_d    = next_idx_q + N'(1);
      end else begin
        retired_d[gnt_id] = 1'b1;
      end
      rr_d = (int'(gnt_id) == CORE_NUMBER - 1) ? '0 : gnt_id + RRW'(1);
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          size_d     = point_cloud_size;
          next_idx_d = '0;
          seed_d     = '0;
          // each run starts arbitration at core 0
          rr_d       = '0;
          state_d    = (point_cloud_size == '0) ? S_DONE : S_SEED;
        end
      end
      S_SEED: begin
        idx_d[seed_q]     = next_idx_q;
        rst_d[seed_q]     = 1'b1;
        retired_d[seed_q] = 1'b0;
        armed_d[seed_q]   = 1'b0;
        next_idx_d        = next_idx_q + N'(1);
        if ((seed_q == RRW'(CORE_NUMBER - 1)) || ((next_idx_q + N'(1)) == size_q)) begin
          state_d = S_RUN;
        end else begin
          seed_d = seed_q + RRW'(1);
        end
      end
      S_RUN: begin
        if (&retired_q) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if ((cnt_q == '0) || transfer) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset aborts any run immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      size_q     <= '0;
      next_idx_q <= '0;
      rr_q       <= '0;
      seed_q     <= '0;
      idx_q      <= '{default: '0};
      buf_q      <= '{default: '0};
      cnt_q      <= '0;
      odata_q    <= '0;
      ocnt_q     <= '0;
      ovalid_q   <= 1'b0;
      retired_q  <= '1;
      rst_q      <= '1;
      armed_q    <= '0;
    end else begin
      state_q    <= state_d;
      size_q     <= size_d;
      next_idx_q <= next_idx_d;
      rr_q       <= rr_d;
      seed_q     <= seed_d;
      idx_q      <= idx_d;
      buf_q      <= buf_d;
      cnt_q      <= cnt_d;
      odata_q    <= odata_d;
      ocnt_q     <= ocnt_d;
      ovalid_q   <= ovalid_d;
      retired_q  <= retired_d;
      rst_q      <= rst_d;
      armed_q    <= armed_d;
    end
  end

  for (genvar i = 0; i < CORE_NUMBER; i++) begin : g_idx
    assign core_point_idx[(i+1)*N-1 -: N] = idx_q[i];
  end

  assign core_reset = rst_q;
  assign out_data   = odata_q;
  assign out_count  = ocnt_q;
  assign out_valid  = ovalid_q;
  assign busy       = (state_q == S_SEED) || (state_q == S_RUN) || (state_q == S_FLUSH);
  assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_core_scheduler.sv
// Directed bench for core_scheduler: the bench plays the validator cores and
// checks emitted outlier words against a queue of expected indices.
module tb_core_scheduler;
  localparam int N    = 16;
  localparam int CN   = 2;
  localparam int PACK = 2;
  localparam int CW   = $clog2(PACK + 1);

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [N-1:0]      point_cloud_size = '0;
  logic [CN-1:0]     core_inlier = '0;
  logic [CN-1:0]     core_outlier = '0;
  logic [CN-1:0]     core_reset;
  logic [N*CN-1:0]   core_point_idx;
  logic [N*PACK-1:0] out_data;
  logic [CW-1:0]     out_count;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic              busy;
  logic              done;

  core_scheduler #(.N(N), .CORE_NUMBER(CN), .PACK(PACK)) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .point_cloud_size(point_cloud_size),
    .core_inlier(core_inlier), .core_outlier(core_outlier),
    .core_reset(core_reset), .core_point_idx(core_point_idx),
    .out_data(out_data), .out_count(out_count), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] mask = '0;
  logic        hold = 1'b0;
  int          exp_q[$];
  int          pending = 0;
  int          issued[64];
  logic [CN-1:0] prev_rst = '1;
  int          ovalid_seen = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Core model: a core presents its verdict once its reset is low.
  task automatic drive_cores();
    logic [5:0] k;
    for (int i = 0; i < CN; i++) begin
      k = core_point_idx[i*N +: 6];
      if (core_reset[i] || hold) begin
        core_inlier[i]  = 1'b0;
        core_outlier[i] = 1'b0;
      end else begin
        core_outlier[i] = mask[k];
        core_inlier[i]  = !mask[k];
      end
    end
  endtask

  task automatic check_word();
    int ecnt;
    int e;
    logic [N-1:0] slot;
    ecnt = (pending >= PACK) ? PACK : pending;
    chk("out_count", 64'(out_count), 64'(ecnt));
    for (int j = 0; j < PACK; j++) begin
      slot = out_data[(PACK-j)*N-1 -: N];
      if (j < ecnt) e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
      else e = 'hFFFF;
      chk("out_slot", 64'(slot), 64'(e));
    end
    pending -= ecnt;
  endtask

  task automatic step();
    logic was_stall;
    logic [N*PACK-1:0] held;
    logic [5:0] k;
    if (out_valid && out_ready) check_word();
    was_stall = out_valid && !out_ready;
    held = out_data;
    @(posedge clock);
    #1;
    if (was_stall) begin
      chk("hold_valid", 64'(out_valid), 64'(1));
      chk("hold_data", 64'(out_data), 64'(held));
    end
    if (out_valid) ovalid_seen++;
    for (int i = 0; i < CN; i++) begin
      if (prev_rst[i] && !core_reset[i]) begin
        k = core_point_idx[i*N +: 6];
        issued[k]++;
      end
    end
    prev_rst = core_reset;
    drive_cores();
  endtask

  task automatic start_run(input int size, input logic [63:0] m);
    mask = m;
    exp_q.delete();
    pending = 0;
    for (int k = 0; k < size; k++) begin
      if (m[k]) begin
        exp_q.push_back(k);
        pending++;
      end
    end
    for (int k = 0; k < 64; k++) issued[k] = 0;
    ovalid_seen = 0;
    point_cloud_size = N'(size);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_done(input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      step();
      n++;
    end
    chk("done_reached", 64'(done), 64'(1));
  endtask

  initial begin
    #12;
    chk("rst_core_reset", 64'(core_reset), 64'(2'b11));
    chk("rst_idx", 64'(core_point_idx), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_count", 64'(out_count), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    // size 0: straight to done
    start_run(0, 64'd0);
    chk("t1_done", 64'(done), 64'(1));
    chk("t1_busy", 64'(busy), 64'(0));
    repeat (3) step();
    chk("t1_no_valid", 64'(ovalid_seen), 64'(0));
    chk("t1_no_issue", 64'(issued[0]), 64'(0));
    chk("t1_core_reset", 64'(core_reset), 64'(2'b11));

    // five inliers
    start_run(5, 64'd0);
    chk("t2_busy", 64'(busy), 64'(1));
    run_done(200);
    for (int k = 0; k < 5; k++) chk("t2_issued", 64'(issued[k]), 64'(1));
    chk("t2_issued5", 64'(issued[5]), 64'(0));
    chk("t2_no_valid", 64'(ovalid_seen), 64'(0));

    // outliers 1,2,3: full word then flushed partial word
    start_run(4, 64'b1110);
    run_done(200);
    repeat (3) step();
    chk("t3_pending", 64'(pending), 64'(0));
    chk("t3_queue", 64'(exp_q.size()), 64'(0));
    chk("t3_valid_clear", 64'(out_valid), 64'(0));
    for (int k = 0; k < 4; k++) chk("t3_issued", 64'(issued[k]), 64'(1));

    // simultaneous results: core 0 first, then core 1
    hold = 1'b1;
    start_run(4, 64'd0);
    repeat (6) step();
    chk("t4_both_waiting", 64'(core_reset), 64'(2'b00));
    hold = 1'b0;
    drive_cores();
    step();
    chk("t4_grant_c0", 64'(core_reset), 64'(2'b01));
    step();
    chk("t4_grant_c1", 64'(core_reset), 64'(2'b10));
    run_done(200);
    for (int k = 0; k < 4; k++) chk("t4_issued", 64'(issued[k]), 64'(1));

    // backpressure with six outliers
    out_ready = 1'b0;
    start_run(6, 64'b111111);
    repeat (30) step();
    chk("t5_valid", 64'(out_valid), 64'(1));
    chk("t5_busy", 64'(busy), 64'(1));
    chk("t5_stalled", 64'(core_reset), 64'(2'b00));
    chk("t5_idx_c0", 64'(core_point_idx[N-1:0]), 64'(4));
    chk("t5_idx_c1", 64'(core_point_idx[2*N-1:N]), 64'(5));
    out_ready = 1'b1;
    run_done(200);
    repeat (3) step();
    chk("t5_pending", 64'(pending), 64'(0));
    chk("t5_queue", 64'(exp_q.size()), 64'(0));
    chk("t5_valid_clear", 64'(out_valid), 64'(0));

    // async reset mid-run, then restart
    start_run(8, 64'b10101010);
    repeat (6) step();
    chk("t6_busy", 64'(busy), 64'(1));
    #3;
    reset_n = 1'b0;
    #1;
    chk("t6_core_reset", 64'(core_reset), 64'(2'b11));
    chk("t6_idx", 64'(core_point_idx), 64'(0));
    chk("t6_busy_clr", 64'(busy), 64'(0));
    chk("t6_done_clr", 64'(done), 64'(0));
    chk("t6_valid_clr", 64'(out_valid), 64'(0));
    core_inlier = '0;
    core_outlier = '0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    prev_rst = core_reset;
    start_run(3, 64'd0);
    run_done(200);
    for (int k = 0; k < 3; k++) chk("t6_issued", 64'(issued[k]), 64'(1));
    chk("t6_issued3", 64'(issued[3]), 64'(0));
    chk("t6_no_valid", 64'(ovalid_seen), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
